// File: rtl/regfile_cmd_ctrl_pkg.sv
// Shared definitions for the register-file command sequencer:
// default opcodes, frame timeout limit and the sequencer state encoding.
package rf_ctrl_pkg;

    localparam logic [7:0] WR_CMD_DEF  = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF  = 8'hBB;
    localparam logic [7:0] TIMEOUT_DEF = 8'd255;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_LSB,
        WR_MSB,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_LSB,
        TX_MSB
    } state_t;

    // An address byte is legal only when every bit above the register
    // file address field is zero.
    function automatic logic addr_ok(input logic [7:0] b, input int unsigned aw);
        return (b >> aw) == 8'h00;
    endfunction

endpackage

// File: rtl/regfile_cmd_ctrl_if.sv
// Bundle of the serial RX/TX handshake and register file bus seen by the
// command sequencer. master = sequencer side, slave = surrounding logic.
interface regfile_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    // serial RX path
    logic [7:0]            RxData;
    logic                  RxValid;
    // serial TX path
    logic [7:0]            TxData;
    logic                  TxValid;
    logic                  TxBusy;
    // register file
    logic [DATA_WIDTH-1:0] RdData;
    logic [DATA_WIDTH-1:0] WrData;
    logic [ADDR_WIDTH-1:0] address;
    logic                  WrEn;
    logic                  RdEn;
    // status pulses
    logic                  CmdErr;
    logic                  Overrun;

    modport master (
        input  RxData, RxValid, TxBusy, RdData,
        output WrData, address, WrEn, RdEn, TxData, TxValid, CmdErr, Overrun
    );

    modport slave (
        output RxData, RxValid, TxBusy, RdData,
        input  WrData, address, WrEn, RdEn, TxData, TxValid, CmdErr, Overrun
    );

endinterface

// File: rtl/regfile_cmd_ctrl_timeout.sv
// Inter-byte idle counter for frame reception. expired is high in the
// cycle whose increment would make the count reach LIMIT.
module frame_timeout_cnt #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    assign expired = en && (cnt == LIMIT - 8'd1);

    // Count idle cycles; clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// Command sequencer in front of the 8x16 register file: parses write/read
// frames from the RX byte stream, drives the register file strobes and
// returns read data as two bytes (LSB first) on the TX path.
module regfile_cmd_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 3,
    parameter logic [7:0] WR_CMD     = WR_CMD_DEF,
    parameter logic [7:0] RD_CMD     = RD_CMD_DEF,
    parameter logic [7:0] TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    regfile_cmd_ctrl_if.master bus
);

    state_t                state;
    logic [DATA_WIDTH-9:0] rd_hi;
    logic                  in_frame;
    logic                  busy_phase;
    logic                  expired;

    assign in_frame   = (state == WR_ADDR) || (state == WR_LSB) ||
                        (state == WR_MSB)  || (state == RD_ADDR);
    assign busy_phase = (state == WR_EXEC) || (state == RD_EXEC) ||
                        (state == RD_WAIT) || (state == TX_LSB)  ||
                        (state == TX_MSB);

    frame_timeout_cnt #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_frame || bus.RxValid),
        .en     (in_frame && !bus.RxValid),
        .expired(expired)
    );

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_hi       <= '0;
            bus.WrData  <= '0;
            bus.address <= '0;
            bus.WrEn    <= 1'b0;
            bus.RdEn    <= 1'b0;
            bus.TxData  <= '0;
            bus.TxValid <= 1'b0;
            bus.CmdErr  <= 1'b0;
            bus.Overrun <= 1'b0;
        end else begin
            bus.WrEn    <= 1'b0;
            bus.RdEn    <= 1'b0;
            bus.CmdErr  <= 1'b0;
            bus.Overrun <= bus.RxValid && busy_phase;

            case (state)
                IDLE: begin
                    if (bus.RxValid) begin
                        if (bus.RxData == WR_CMD) begin
                            state <= WR_ADDR;
                        end else if (bus.RxData == RD_CMD) begin
                            state <= RD_ADDR;
                        end else begin
                            bus.CmdErr <= 1'b1;
                        end
                    end
                end

                WR_ADDR, RD_ADDR: begin
                    if (bus.RxValid) begin
                        if (!addr_ok(bus.RxData, ADDR_WIDTH)) begin
                            bus.CmdErr <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bus.address <= bus.RxData[ADDR_WIDTH-1:0];
                            if (state == WR_ADDR) begin
                                state <= WR_LSB;
                            end else begin
                                bus.RdEn <= 1'b1;
                                state    <= RD_EXEC;
                            end
                        end
                    end else if (expired) begin
                        bus.CmdErr <= 1'b1;
                        state      <= IDLE;
                    end
                end

                WR_LSB: begin
                    if (bus.RxValid) begin
                        bus.WrData[7:0] <= bus.RxData;
                        state           <= WR_MSB;
                    end else if (expired) begin
                        bus.CmdErr <= 1'b1;
                        state      <= IDLE;
                    end
                end

                WR_MSB: begin
                    if (bus.RxValid) begin
                        bus.WrData[DATA_WIDTH-1:8] <= bus.RxData;
                        bus.WrEn                   <= 1'b1;
                        state                      <= WR_EXEC;
                    end else if (expired) begin
                        bus.CmdErr <= 1'b1;
                        state      <= IDLE;
                    end
                end

                WR_EXEC: begin
                    state <= IDLE;
                end

                RD_EXEC: begin
                    state <= RD_WAIT;
                end

                // The low byte goes straight into TxData, which then acts as
                // the low half of the read buffer; only the high byte is kept.
                RD_WAIT: begin
                    bus.TxData  <= bus.RdData[7:0];
                    rd_hi       <= bus.RdData[DATA_WIDTH-1:8];
                    bus.TxValid <= 1'b1;
                    state       <= TX_LSB;
                end

                TX_LSB: begin
                    if (!bus.TxBusy) begin
                        bus.TxData <= rd_hi;
                        state      <= TX_MSB;
                    end
                end

                TX_MSB: begin
                    if (!bus.TxBusy) begin
                        bus.TxValid <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Self-checking bench for regfile_cmd_ctrl: table-driven write/read/error
// vectors followed by hand-written timeout, back-to-back and reset sequences.
module tb_regfile_cmd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_cmd_ctrl_if bus_if ();

    regfile_cmd_ctrl #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3),
        .WR_CMD    (8'hAA),
        .RD_CMD    (8'hBB),
        .TIMEOUT   (8'd255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Register file model: registered read, one cycle after RdEn.
    logic [15:0] mem [8];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            bus_if.RdData <= '0;
        end else begin
            if (bus_if.WrEn) mem[bus_if.address] <= bus_if.WrData;
            if (bus_if.RdEn) bus_if.RdData <= mem[bus_if.address];
        end
    end

    // Strobe monitor.
    int          wr_cnt  = 0;
    int          overlap = 0;
    logic [2:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (bus_if.WrEn && bus_if.RdEn) overlap++;
            if (bus_if.WrEn) begin
                wr_cnt++;
                last_wr_addr = bus_if.address;
                last_wr_data = bus_if.WrData;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.RxValid = 1'b1;
        bus_if.RxData  = b;
        tick();
        bus_if.RxValid = 1'b0;
        bus_if.RxData  = '0;
    endtask

    function automatic logic [31:0] all_outs();
        return {bus_if.WrEn, bus_if.RdEn, bus_if.TxValid, bus_if.CmdErr, bus_if.Overrun,
                bus_if.TxData, bus_if.address, bus_if.WrData};
    endfunction

    typedef struct {
        logic        rxv;
        logic [7:0]  rxd;
        logic        busy;
        logic        wren;
        logic        rden;
        logic        txv;
        logic [7:0]  txd;
        logic        err;
        logic        ovr;
        logic [2:0]  addr;
        logic [15:0] wrd;
    } vec_t;

    vec_t vt [25];

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] got [4];
        int         nbytes;
        logic       err_early;
        logic       seen;

        // rxv rxd busy | wren rden txv txd err ovr addr wrdata
        vt[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000};
        vt[1]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h0000};
        vt[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h0034};
        vt[3]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[5]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 3'd5, 16'h1234};
        for (int i = 9; i <= 18; i++)
            vt[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[13] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 3'd5, 16'h1234};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[21] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 3'd5, 16'h1234};
        vt[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[23] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 3'd5, 16'h1234};
        vt[24] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 3'd5, 16'h1234};

        bus_if.RxValid = 1'b0;
        bus_if.RxData  = '0;
        bus_if.TxBusy  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_reset_idle", all_outs(), 32'h0);

        // Table: write 5=1234, read it back with TX stall and overrun, errors
        for (int i = 0; i < 25; i++) begin
            bus_if.RxValid = vt[i].rxv;
            bus_if.RxData  = vt[i].rxd;
            bus_if.TxBusy  = vt[i].busy;
            tick();
            chk($sformatf("row%0d_WrEn", i),    32'(bus_if.WrEn),    32'(vt[i].wren));
            chk($sformatf("row%0d_RdEn", i),    32'(bus_if.RdEn),    32'(vt[i].rden));
            chk($sformatf("row%0d_TxValid", i), 32'(bus_if.TxValid), 32'(vt[i].txv));
            chk($sformatf("row%0d_TxData", i),  32'(bus_if.TxData),  32'(vt[i].txd));
            chk($sformatf("row%0d_CmdErr", i),  32'(bus_if.CmdErr),  32'(vt[i].err));
            chk($sformatf("row%0d_Overrun", i), 32'(bus_if.Overrun), 32'(vt[i].ovr));
            chk($sformatf("row%0d_address", i), 32'(bus_if.address), 32'(vt[i].addr));
            chk($sformatf("row%0d_WrData", i),  32'(bus_if.WrData),  32'(vt[i].wrd));
        end
        bus_if.RxValid = 1'b0;
        bus_if.RxData  = '0;
        bus_if.TxBusy  = 1'b0;
        chk("table_write_count", 32'(wr_cnt), 32'd1);

        // Timeout: AA,01 then silence; error on the 255th idle cycle
        send_byte(8'hAA);
        send_byte(8'h01);
        chk("timeout_addr_latched", 32'(bus_if.address), 32'd1);
        err_early = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (bus_if.CmdErr) err_early = 1'b1;
        end
        chk("timeout_not_early", 32'(err_early), 32'd0);
        tick();
        chk("timeout_cmderr", 32'(bus_if.CmdErr), 32'd1);
        tick();
        chk("timeout_cmderr_pulse", 32'(bus_if.CmdErr), 32'd0);
        send_byte(8'h34);
        chk("timeout_back_in_idle", 32'(bus_if.CmdErr), 32'd1);
        chk("timeout_no_write", 32'(wr_cnt), 32'd1);

        // Back-to-back: write 7=FFFF, read opcode on the first IDLE cycle
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'hFF);
        send_byte(8'hFF);
        chk("b2b_wren", 32'(bus_if.WrEn), 32'd1);
        tick();
        send_byte(8'hBB);
        chk("b2b_no_overrun", 32'(bus_if.Overrun), 32'd0);
        send_byte(8'h07);
        chk("b2b_rden", 32'(bus_if.RdEn), 32'd1);
        nbytes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.TxValid && nbytes < 4) begin
                got[nbytes] = bus_if.TxData;
                nbytes++;
            end
        end
        chk("b2b_byte_count", 32'(nbytes), 32'd2);
        chk("b2b_byte0", 32'(got[0]), 32'hFF);
        chk("b2b_byte1", 32'(got[1]), 32'hFF);
        chk("b2b_last_write", {13'd0, last_wr_addr, last_wr_data}, {13'd0, 3'd7, 16'hFFFF});
        chk("b2b_write_count", 32'(wr_cnt), 32'd2);

        // Reset in TX_MSB, then a normal write frame
        bus_if.TxBusy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h07);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus_if.TxValid) seen = 1'b1;
        end
        chk("rst_tx_started", 32'(seen), 32'd1);
        chk("rst_tx_lsb", 32'(bus_if.TxData), 32'hFF);
        bus_if.TxBusy = 1'b0;
        tick();
        bus_if.TxBusy = 1'b1;
        tick();
        chk("rst_in_tx_msb", {23'd0, bus_if.TxValid, bus_if.TxData}, {23'd0, 1'b1, 8'hFF});
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", all_outs(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.TxBusy = 1'b0;
        tick();
        chk("rst_release_idle", all_outs(), 32'h0);
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'hCD);
        send_byte(8'hAB);
        chk("rst_frame_wren", {12'd0, bus_if.WrEn, bus_if.address, bus_if.WrData},
            {12'd0, 1'b1, 3'd3, 16'hABCD});
        tick();
        chk("rst_frame_wren_pulse", 32'(bus_if.WrEn), 32'd0);
        chk("final_write_count", 32'(wr_cnt), 32'd3);
        chk("no_wr_rd_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
